// File: rtl/driver_cell_pkg.sv
// ---------------------------------------------------------------------------
// driver_cell_pkg
// Shared definitions for the driver cell model:
//   - drv_state_t    : power/operating state of the cell
//   - supply windows : inclusive acceptance limits for the three supplies
//   - DRV_Z          : real value used to represent an undriven (Z) output
//   - mismatch_code  : elaboration-time pseudo-random mismatch generator
//   - drive_level    : per-bit output level for a given state
// ---------------------------------------------------------------------------

`ifndef wrealZState
`define wrealZState 1.0e30
`endif

package driver_cell_pkg;

    // Sentinel real value meaning "not driven".
    localparam real DRV_Z = `wrealZState;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FAULT  = 2'd3
    } drv_state_t;

    // Supply acceptance windows (reference +/- tolerance), inclusive.
    localparam real VDDA_1P8_MIN = 1.71;
    localparam real VDDA_1P8_MAX = 1.89;
    localparam real VDDA_0P8_MIN = 0.76;
    localparam real VDDA_0P8_MAX = 0.84;
    localparam real VSSA_MIN     = -0.05;
    localparam real VSSA_MAX     = 0.05;

    // Mismatch coefficients are quantised to 1/MISMATCH_SCALE.
    localparam real MISMATCH_SCALE = 1.0e5;

    // Independent seeds for the four coefficient arrays.
    localparam int SEED_BIN    = 1;
    localparam int SEED_BINB   = 2;
    localparam int SEED_THERM  = 3;
    localparam int SEED_THERMB = 4;

    // Returns an integer code uniformly spread over [-steps, steps-1].
    // Evaluated at elaboration only, so the coefficients are fixed for the
    // whole run and survive any reset.
    function automatic int mismatch_code(input int seed, input int idx, input int steps);
        logic [31:0] x;
        x = (32'(seed) * 32'h9E37_79B9) ^ ((32'(idx) + 32'd1) * 32'h85EB_CA6B);
        for (int r = 0; r < 3; r++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        if (steps <= 0) begin
            return 0;
        end
        return int'({1'b0, x[30:0]} % 32'(2 * steps)) - steps;
    endfunction

    // Output level for one switch: Z when not operating, 0.0 in FAULT,
    // q*(1+m) in ACTIVE.
    function automatic real drive_level(input logic q, input real m, input drv_state_t st);
        real lvl;
        lvl = DRV_Z;
        if (st == ST_ACTIVE) begin
            lvl = q ? (1.0 + m) : 0.0;
        end else if (st == ST_FAULT) begin
            lvl = 0.0;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/supply_monitor.sv
// ---------------------------------------------------------------------------
// supply_monitor
// Checks the three supplies against their windows every cycle and debounces
// the result in both directions.
// Ports:
//   clk, rstn                         : clock, synchronous active-low reset
//   vddana_1p8, vddana_0p8, vssana    : supply levels (real)
//   supply_ok                         : all supplies inside their windows now
//   fault_req                         : this cycle is the DEBOUNCE-th bad sample
//                                       in a row (or later)
//   clear_req                         : this cycle is the DEBOUNCE-th good sample
//                                       in a row (or later)
// ---------------------------------------------------------------------------
module supply_monitor
    import driver_cell_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  real  vddana_1p8,
    input  real  vddana_0p8,
    input  real  vssana,
    output logic supply_ok,
    output logic fault_req,
    output logic clear_req
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    logic [3:0] r_bad_cnt;
    logic [3:0] r_good_cnt;

    always_comb begin
        supply_ok = (vddana_1p8 >= VDDA_1P8_MIN) && (vddana_1p8 <= VDDA_1P8_MAX) &&
                    (vddana_0p8 >= VDDA_0P8_MIN) && (vddana_0p8 <= VDDA_0P8_MAX) &&
                    (vssana     >= VSSA_MIN)     && (vssana     <= VSSA_MAX);
    end

    // Counters hold the number of consecutive samples already seen; the
    // request fires on the sample that completes the run, so the FSM moves
    // on exactly that edge. Both saturate at DEBOUNCE-1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bad_cnt  <= '0;
            r_good_cnt <= '0;
        end else if (supply_ok) begin
            r_bad_cnt  <= '0;
            r_good_cnt <= (r_good_cnt == DB_LAST) ? r_good_cnt : r_good_cnt + 4'd1;
        end else begin
            r_good_cnt <= '0;
            r_bad_cnt  <= (r_bad_cnt == DB_LAST) ? r_bad_cnt : r_bad_cnt + 4'd1;
        end
    end

    assign fault_req = !supply_ok && (r_bad_cnt == DB_LAST);
    assign clear_req = supply_ok && (r_good_cnt == DB_LAST);

endmodule

// File: rtl/driver_cell_sync.sv
// ---------------------------------------------------------------------------
// driver_cell_sync
// Clocked behavioural model of a segmented DAC switch-driver cell with
// power sequencing, supply fault handling and static per-switch mismatch.
// Ports:
//   clk, rstn                   : clock, synchronous active-low reset
//   datain/datainb   [NBIN]     : binary code and its complement
//   datatherm/datathermb[NTHERM]: thermometer code and its complement
//   pdb                         : power-down negate (1 = run)
//   vddana_1p8/0p8, vssana      : supplies (real)
//   databinout/b, datathermout/b: switch drive levels (real arrays)
//   ready                       : cell ACTIVE
//   fault                       : cell in supply FAULT
//   comp_err                    : sticky, a data bit equalled its complement
//                                 while ACTIVE
// ---------------------------------------------------------------------------
module driver_cell_sync
    import driver_cell_pkg::*;
#(
    parameter int  NBIN          = 7,
    parameter int  NTHERM        = 17,
    parameter int  SETTLE_CYCLES = 16,
    parameter int  DEBOUNCE      = 4,
    parameter int  MISMATCH_EN   = 1,
    parameter real MISMATCH_MAX  = 0.02
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NBIN-1:0]   datain,
    input  logic [NBIN-1:0]   datainb,
    input  logic [NTHERM-1:0] datatherm,
    input  logic [NTHERM-1:0] datathermb,
    input  logic              pdb,
    input  real               vddana_1p8,
    input  real               vddana_0p8,
    input  real               vssana,
    output real               databinout    [NBIN],
    output real               databinoutb   [NBIN],
    output real               datathermout  [NTHERM],
    output real               datathermoutb [NTHERM],
    output logic              ready,
    output logic              fault,
    output logic              comp_err
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    // Number of quantisation steps in the mismatch bound; zero disables it.
    localparam int M_STEPS = (MISMATCH_EN != 0) ? int'(MISMATCH_MAX * MISMATCH_SCALE) : 0;

    drv_state_t        r_state;
    drv_state_t        w_state_next;
    logic [7:0]        r_settle_cnt;
    logic [7:0]        w_settle_next;

    logic [NBIN-1:0]   r_datain;
    logic [NBIN-1:0]   r_datainb;
    logic [NTHERM-1:0] r_datatherm;
    logic [NTHERM-1:0] r_datathermb;

    logic              w_supply_ok;
    logic              w_fault_req;
    logic              w_clear_req;
    logic              w_comp_viol;

    supply_monitor #(
        .DEBOUNCE (DEBOUNCE)
    ) u_supply_monitor (
        .clk        (clk),
        .rstn       (rstn),
        .vddana_1p8 (vddana_1p8),
        .vddana_0p8 (vddana_0p8),
        .vssana     (vssana),
        .supply_ok  (w_supply_ok),
        .fault_req  (w_fault_req),
        .clear_req  (w_clear_req)
    );

    // Retiming stage: always captures, whatever the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_datain     <= '0;
            r_datainb    <= '0;
            r_datatherm  <= '0;
            r_datathermb <= '0;
        end else begin
            r_datain     <= datain;
            r_datainb    <= datainb;
            r_datatherm  <= datatherm;
            r_datathermb <= datathermb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_OFF;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    // Supply fault outranks every pdb-driven move.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_fault_req) begin
                    w_state_next = ST_FAULT;
                end else if (pdb && w_supply_ok) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = '0;
                end
            end
            ST_SETTLE: begin
                if (w_fault_req) begin
                    w_state_next = ST_FAULT;
                end else if (!pdb) begin
                    w_state_next = ST_OFF;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_settle_next = r_settle_cnt + 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (w_fault_req) begin
                    w_state_next = ST_FAULT;
                end else if (!pdb) begin
                    w_state_next = ST_OFF;
                end
            end
            ST_FAULT: begin
                if (w_clear_req) begin
                    w_state_next = ST_OFF;
                end
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    // A bit equal to its complement (both 0 or both 1) is a violation.
    assign w_comp_viol = (|(r_datain ~^ r_datainb)) | (|(r_datatherm ~^ r_datathermb));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            comp_err <= 1'b0;
        end else if ((r_state == ST_ACTIVE) && w_comp_viol) begin
            comp_err <= 1'b1;
        end
    end

    assign ready = (r_state == ST_ACTIVE);
    assign fault = (r_state == ST_FAULT);

    // Each switch gets its own fixed coefficient, computed at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < NBIN; gi++) begin : g_bin
            localparam real M_P = real'(mismatch_code(SEED_BIN,  gi, M_STEPS)) / MISMATCH_SCALE;
            localparam real M_N = real'(mismatch_code(SEED_BINB, gi, M_STEPS)) / MISMATCH_SCALE;
            assign databinout[gi]  = drive_level(r_datain[gi],  M_P, r_state);
            assign databinoutb[gi] = drive_level(r_datainb[gi], M_N, r_state);
        end
        for (gi = 0; gi < NTHERM; gi++) begin : g_therm
            localparam real M_P = real'(mismatch_code(SEED_THERM,  gi, M_STEPS)) / MISMATCH_SCALE;
            localparam real M_N = real'(mismatch_code(SEED_THERMB, gi, M_STEPS)) / MISMATCH_SCALE;
            assign datathermout[gi]  = drive_level(r_datatherm[gi],  M_P, r_state);
            assign datathermoutb[gi] = drive_level(r_datathermb[gi], M_N, r_state);
        end
    endgenerate

endmodule

// File: tb/tb_driver_cell_sync.sv
module tb_driver_cell_sync;

    localparam int  NB = 7;
    localparam int  NT = 17;
    localparam real ZV = driver_cell_pkg::DRV_Z;
    localparam real EPS = 1.0e-9;

    logic          clk;
    logic          rstn;
    logic          pdb;
    logic [NB-1:0] datain, datainb;
    logic [NT-1:0] datatherm, datathermb;
    real           v18, v08, vss;

    real  bo0 [NB];
    real  bob0[NB];
    real  to0 [NT];
    real  tob0[NT];
    logic ready0, fault0, cerr0;

    real  bo1 [NB];
    real  bob1[NB];
    real  to1 [NT];
    real  tob1[NT];
    logic ready1, fault1, cerr1;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    driver_cell_sync #(
        .NBIN(NB), .NTHERM(NT), .SETTLE_CYCLES(16), .DEBOUNCE(4),
        .MISMATCH_EN(0), .MISMATCH_MAX(0.02)
    ) dut0 (
        .clk(clk), .rstn(rstn), .datain(datain), .datainb(datainb),
        .datatherm(datatherm), .datathermb(datathermb), .pdb(pdb),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .databinout(bo0), .databinoutb(bob0), .datathermout(to0), .datathermoutb(tob0),
        .ready(ready0), .fault(fault0), .comp_err(cerr0)
    );

    driver_cell_sync #(
        .NBIN(NB), .NTHERM(NT), .SETTLE_CYCLES(16), .DEBOUNCE(4),
        .MISMATCH_EN(1), .MISMATCH_MAX(0.02)
    ) dut1 (
        .clk(clk), .rstn(rstn), .datain(datain), .datainb(datainb),
        .datatherm(datatherm), .datathermb(datathermb), .pdb(pdb),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .databinout(bo1), .databinoutb(bob1), .datathermout(to1), .datathermoutb(tob1),
        .ready(ready1), .fault(fault1), .comp_err(cerr1)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_bin(input logic [NB-1:0] v);
        datain  = v;
        datainb = ~v;
    endtask

    task automatic set_therm(input logic [NT-1:0] v);
        datatherm  = v;
        datathermb = ~v;
    endtask

    task automatic test_reset;
        rstn = 1'b0; pdb = 1'b0;
        v18 = 1.80; v08 = 0.80; vss = 0.0;
        set_bin('0); set_therm('0);
        tick(2);
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", ready0); end
        n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b expected 0", fault0); end
        n_checks++; if (cerr0 !== 1'b0) begin n_fail++; $display("FAIL reset_comp_err got %b expected 0", cerr0); end
        n_checks++; if (bo0[0] != ZV) begin n_fail++; $display("FAIL reset_binout0 got %g expected Z %g", bo0[0], ZV); end
        n_checks++; if (tob1[16] != ZV) begin n_fail++; $display("FAIL reset_thermoutb16 got %g expected Z %g", tob1[16], ZV); end
        $display("test_reset done");
    endtask

    task automatic test_powerup;
        rstn = 1'b1;
        set_bin(7'h7F); set_therm(17'h0000F);
        pdb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL powerup_early_ready cycle %0d got %b expected 0", i + 1, ready0); end
            n_checks++; if (bo0[0] != ZV) begin n_fail++; $display("FAIL powerup_z cycle %0d got %g expected Z", i + 1, bo0[0]); end
        end
        tick(1);
        n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL powerup_ready cycle 17 got %b expected 1", ready0); end
        n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL powerup_ready_dut1 got %b expected 1", ready1); end
        n_checks++; if (bo0[6] != 1.0) begin n_fail++; $display("FAIL powerup_binout6 got %g expected 1.0", bo0[6]); end
        n_checks++; if (to0[3] != 1.0) begin n_fail++; $display("FAIL powerup_thermout3 got %g expected 1.0", to0[3]); end
        n_checks++; if (to0[4] != 0.0) begin n_fail++; $display("FAIL powerup_thermout4 got %g expected 0.0", to0[4]); end
        n_checks++; if (tob0[4] != 1.0) begin n_fail++; $display("FAIL powerup_thermoutb4 got %g expected 1.0", tob0[4]); end
        $display("test_powerup done");
    endtask

    task automatic test_data;
        logic [NB-1:0] pb;
        logic [NT-1:0] pt;
        pb = 7'h55;
        pt = 17'h000FF;
        set_bin(pb); set_therm(pt);
        // Registered stage: the previous code (7F) is still on the outputs.
        n_checks++; if (bo0[1] != 1.0) begin n_fail++; $display("FAIL data_latency got %g expected 1.0", bo0[1]); end
        tick(1);
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (bo0[k] != (pb[k] ? 1.0 : 0.0)) begin n_fail++; $display("FAIL data_bin[%0d] got %g expected %g", k, bo0[k], pb[k] ? 1.0 : 0.0); end
            n_checks++;
            if (bob0[k] != (pb[k] ? 0.0 : 1.0)) begin n_fail++; $display("FAIL data_binb[%0d] got %g expected %g", k, bob0[k], pb[k] ? 0.0 : 1.0); end
        end
        for (int k = 0; k < NT; k++) begin
            n_checks++;
            if (to0[k] != (pt[k] ? 1.0 : 0.0)) begin n_fail++; $display("FAIL data_therm[%0d] got %g expected %g", k, to0[k], pt[k] ? 1.0 : 0.0); end
        end
        $display("test_data done");
    endtask

    task automatic test_mismatch;
        int ndiff;
        ndiff = 0;
        set_bin('1); set_therm('1);
        tick(1);
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (bo1[k] < 0.98 - EPS || bo1[k] > 1.02 + EPS) begin n_fail++; $display("FAIL mm_bin[%0d] got %g expected in [0.98,1.02]", k, bo1[k]); end
            n_checks++;
            if (bob1[k] != 0.0) begin n_fail++; $display("FAIL mm_binb[%0d] got %g expected 0.0", k, bob1[k]); end
            n_checks++;
            if (bo0[k] != 1.0) begin n_fail++; $display("FAIL nomm_bin[%0d] got %g expected 1.0", k, bo0[k]); end
            if (bo1[k] != 1.0) ndiff++;
        end
        for (int k = 0; k < NT; k++) begin
            n_checks++;
            if (to1[k] < 0.98 - EPS || to1[k] > 1.02 + EPS) begin n_fail++; $display("FAIL mm_therm[%0d] got %g expected in [0.98,1.02]", k, to1[k]); end
            n_checks++;
            if (tob1[k] != 0.0) begin n_fail++; $display("FAIL mm_thermb[%0d] got %g expected 0.0", k, tob1[k]); end
            if (to1[k] != 1.0) ndiff++;
        end
        n_checks++; if (ndiff == 0) begin n_fail++; $display("FAIL mm_applied got %0d perturbed outputs expected >0", ndiff); end
        $display("test_mismatch done");
    endtask

    task automatic test_comp_err;
        datathermb[3] = 1'b1;
        n_checks++; if (cerr0 !== 1'b0) begin n_fail++; $display("FAIL cerr_pre got %b expected 0", cerr0); end
        tick(1);
        n_checks++; if (cerr0 !== 1'b0) begin n_fail++; $display("FAIL cerr_reg_stage got %b expected 0", cerr0); end
        tick(1);
        n_checks++; if (cerr0 !== 1'b1) begin n_fail++; $display("FAIL cerr_set got %b expected 1", cerr0); end
        set_therm('1);
        tick(3);
        n_checks++; if (cerr0 !== 1'b1) begin n_fail++; $display("FAIL cerr_sticky got %b expected 1", cerr0); end
        n_checks++; if (cerr1 !== 1'b1) begin n_fail++; $display("FAIL cerr_sticky_dut1 got %b expected 1", cerr1); end
        $display("test_comp_err done");
    endtask

    task automatic test_pdb_drop;
        n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL pdb_pre_ready got %b expected 1", ready0); end
        pdb = 1'b0;
        tick(1);
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL pdb_ready got %b expected 0", ready0); end
        n_checks++; if (bo0[0] != ZV) begin n_fail++; $display("FAIL pdb_binout0 got %g expected Z", bo0[0]); end
        n_checks++; if (tob0[0] != ZV) begin n_fail++; $display("FAIL pdb_thermoutb0 got %g expected Z", tob0[0]); end
        pdb = 1'b1;
        tick(17);
        n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL pdb_repower_ready got %b expected 1", ready0); end
        $display("test_pdb_drop done");
    endtask

    task automatic test_fault;
        v18 = 1.71;
        tick(5);
        n_checks++; if (fault0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL fault_low_edge got fault=%b ready=%b expected 0/1", fault0, ready0); end
        v18 = 1.89;
        tick(5);
        n_checks++; if (fault0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL fault_high_edge got fault=%b ready=%b expected 0/1", fault0, ready0); end
        v18 = 1.60;
        tick(3);
        n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL fault_3bad got %b expected 0", fault0); end
        n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL fault_3bad_ready got %b expected 1", ready0); end
        v18 = 1.80;
        tick(1);
        v18 = 1.60;
        tick(3);
        n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL fault_debounce_reset got %b expected 0", fault0); end
        tick(1);
        n_checks++; if (fault0 !== 1'b1) begin n_fail++; $display("FAIL fault_4bad got %b expected 1", fault0); end
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL fault_ready got %b expected 0", ready0); end
        n_checks++; if (bo0[0] != 0.0) begin n_fail++; $display("FAIL fault_binout0 got %g expected 0.0", bo0[0]); end
        n_checks++; if (tob1[5] != 0.0) begin n_fail++; $display("FAIL fault_thermoutb5 got %g expected 0.0", tob1[5]); end
        v18 = 1.80;
        tick(3);
        n_checks++; if (fault0 !== 1'b1) begin n_fail++; $display("FAIL fault_3good got %b expected 1", fault0); end
        tick(1);
        n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL fault_clear got %b expected 0", fault0); end
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL fault_clear_ready got %b expected 0", ready0); end
        n_checks++; if (bo0[0] != ZV) begin n_fail++; $display("FAIL fault_clear_z got %g expected Z", bo0[0]); end
        $display("test_fault done");
    endtask

    task automatic test_reset_midstate;
        tick(1);   // OFF -> SETTLE with pdb held high
        n_checks++; if (cerr0 !== 1'b1) begin n_fail++; $display("FAIL mid_cerr_held got %b expected 1", cerr0); end
        rstn = 1'b0;
        tick(1);
        n_checks++; if (cerr0 !== 1'b0) begin n_fail++; $display("FAIL mid_settle_cerr got %b expected 0", cerr0); end
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL mid_settle_ready got %b expected 0", ready0); end
        rstn = 1'b1;
        tick(17);
        n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL mid_repower_ready got %b expected 1", ready0); end
        n_checks++; if (bo0[2] != 1.0) begin n_fail++; $display("FAIL mid_repower_binout2 got %g expected 1.0", bo0[2]); end
        n_checks++; if (cerr0 !== 1'b0) begin n_fail++; $display("FAIL mid_clean_cerr got %b expected 0", cerr0); end
        rstn = 1'b0;
        tick(1);
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL mid_active_ready got %b expected 0", ready0); end
        n_checks++; if (to0[0] != ZV) begin n_fail++; $display("FAIL mid_active_z got %g expected Z", to0[0]); end
        rstn = 1'b1;
        v08 = 0.70;
        tick(4);
        n_checks++; if (fault0 !== 1'b1) begin n_fail++; $display("FAIL mid_off_fault got %b expected 1", fault0); end
        rstn = 1'b0;
        v08 = 0.80;
        tick(1);
        n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL mid_fault_reset got %b expected 0", fault0); end
        n_checks++; if (bo0[0] != ZV) begin n_fail++; $display("FAIL mid_fault_reset_z got %g expected Z", bo0[0]); end
        $display("test_reset_midstate done");
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_data();
        test_mismatch();
        test_comp_err();
        test_pdb_drop();
        test_fault();
        test_reset_midstate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
